pin_entry_collector: RTL and testbench

PIN_ENTRY_COLLECTOR -- requirements
Module: pin_entry_collector

---
 rtl/pin_entry_collector.sv | 152 +++++++++++++++
 tb/tb_pin_entry_collector.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pin_entry_collector.sv
// Collects a 4-digit BCD PIN from a keypad and hands it to the gate controller with a one-cycle ack.
// Optional inter-key idle timeout is compiled in when PIN_ENTRY_TIMEOUT_EN is defined.
module pin_entry_collector #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_clear,
  input  logic        key_enter,
  output logic [15:0] code,
  output logic        code_ack,
  output logic [2:0]  digit_count,
  output logic        entry_error,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL, SEND} state_t;

  state_t      state, state_nxt;
  logic [15:0] buffer, buffer_nxt, code_nxt;
  logic [2:0]  count_nxt;
  logic        ack_nxt, err_nxt;
  logic        digit_ok;
  logic        idle_expire;

  assign digit_ok = (key_digit <= 4'd9);

`ifdef PIN_ENTRY_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        any_key, idle_run;

  // The counter only ticks while a partial PIN is waiting and no key arrives.
  assign any_key     = key_valid | key_clear | key_enter;
  assign idle_run    = enable && !any_key && (digit_count != 3'd0) &&
                       ((state == COLLECT) || (state == FULL));
  assign idle_expire = idle_run && (idle_cnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= 16'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= idle_expire;
      if (idle_run && !idle_expire)
        idle_cnt <= idle_cnt + 16'd1;
      else
        idle_cnt <= 16'd0;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign idle_expire        = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      buffer      <= 16'h0000;
      code        <= 16'h0000;
      code_ack    <= 1'b0;
      digit_count <= 3'd0;
      entry_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      buffer      <= buffer_nxt;
      code        <= code_nxt;
      code_ack    <= ack_nxt;
      digit_count <= count_nxt;
      entry_error <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    buffer_nxt = buffer;
    count_nxt  = digit_count;
    code_nxt   = code;
    ack_nxt    = 1'b0;
    err_nxt    = 1'b0;

    if (!enable) begin
      state_nxt  = IDLE;
      buffer_nxt = 16'h0000;
      count_nxt  = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt  = COLLECT;
          buffer_nxt = 16'h0000;
          count_nxt  = 3'd0;
        end
        COLLECT: begin
          if (key_clear) begin
            buffer_nxt = 16'h0000;
            count_nxt  = 3'd0;
          end else if (key_enter) begin
            err_nxt    = 1'b1;
            buffer_nxt = 16'h0000;
            count_nxt  = 3'd0;
          end else if (key_valid) begin
            if (!digit_ok) begin
              err_nxt = 1'b1;
            end else begin
              buffer_nxt = {buffer[11:0], key_digit};
              count_nxt  = digit_count + 3'd1;
              if (digit_count == 3'd3)
                state_nxt = FULL;
            end
          end else if (idle_expire) begin
            buffer_nxt = 16'h0000;
            count_nxt  = 3'd0;
          end
        end
        FULL: begin
          if (key_clear) begin
            state_nxt  = COLLECT;
            buffer_nxt = 16'h0000;
            count_nxt  = 3'd0;
          end else if (key_enter) begin
            state_nxt = SEND;
          end else if (key_valid) begin
            err_nxt = 1'b1;
          end else if (idle_expire) begin
            state_nxt  = COLLECT;
            buffer_nxt = 16'h0000;
            count_nxt  = 3'd0;
          end
        end
        SEND: begin
          // Publish the PIN for one cycle, then allow a fresh attempt.
          code_nxt   = buffer;
          ack_nxt    = 1'b1;
          buffer_nxt = 16'h0000;
          count_nxt  = 3'd0;
          state_nxt  = COLLECT;
        end
        default: begin
          state_nxt  = IDLE;
          buffer_nxt = 16'h0000;
          count_nxt  = 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pin_entry_collector.sv
// Bench for pin_entry_collector: directed scenarios with literal expectations, then random keypad
// traffic, all compared every cycle against a queue-based model of the PIN entry rules.
module tb_pin_entry_collector;

  localparam logic [15:0] T = 16'd8;
`ifdef PIN_ENTRY_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, key_valid, key_clear, key_enter;
  logic [3:0]  key_digit;
  logic [15:0] code;
  logic        code_ack, entry_error, timeout;
  logic [2:0]  digit_count;

  pin_entry_collector #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .enable(enable), .key_valid(key_valid), .key_digit(key_digit),
    .key_clear(key_clear), .key_enter(key_enter), .code(code), .code_ack(code_ack),
    .digit_count(digit_count), .entry_error(entry_error), .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the buffered digits as a queue, plus whether a session is live and a submit is pending.
  int          q[$];
  bit          active = 1'b0, sending = 1'b0;
  int          idle = 0;
  logic [15:0] m_code = 16'h0;
  bit          m_ack = 1'b0, m_err = 1'b0, m_tmo = 1'b0;

  function automatic logic [15:0] pack(input int d0, input int d1, input int d2, input int d3);
    return 16'(d0 * 4096 + d1 * 256 + d2 * 16 + d3);
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      q.delete(); active = 0; sending = 0; idle = 0;
      m_code = 16'h0; m_ack = 0; m_err = 0; m_tmo = 0;
    end else begin
      m_ack = 0; m_err = 0; m_tmo = 0;
      if (!enable) begin
        q.delete(); active = 0; sending = 0; idle = 0;
      end else if (!active) begin
        active = 1; q.delete(); idle = 0;
      end else if (sending) begin
        m_code = pack(q[0], q[1], q[2], q[3]);
        m_ack = 1; q.delete(); sending = 0; idle = 0;
      end else begin
        if (key_clear) q.delete();
        else if (key_enter) begin
          if (q.size() == 4) sending = 1;
          else begin m_err = 1; q.delete(); end
        end else if (key_valid) begin
          if (q.size() == 4 || key_digit > 4'd9) m_err = 1;
          else q.push_back(int'(key_digit));
        end
        if (TMO_EN && !(key_valid || key_clear || key_enter) && q.size() > 0) begin
          idle++;
          if (idle == int'(T)) begin q.delete(); m_tmo = 1; idle = 0; end
        end else idle = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("code", code, m_code);
      check("code_ack", code_ack, m_ack);
      check("digit_count", digit_count, q.size());
      check("entry_error", entry_error, m_err);
      check("timeout", timeout, m_tmo);
    end
  end

  task automatic step(input logic v, input logic [3:0] d, input logic c, input logic e);
    key_valid = v; key_digit = d; key_clear = c; key_enter = e;
    @(negedge clk);
    key_valid = 0; key_clear = 0; key_enter = 0;
  endtask

  task automatic digit(input logic [3:0] d);
    step(1, d, 0, 0);
  endtask

  task automatic idle_step();
    step(0, 4'd0, 0, 0);
  endtask

  int quiet = 0;

  initial begin
    rst = 1; enable = 0; key_valid = 0; key_digit = 0; key_clear = 0; key_enter = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("rst_code", code, 16'h0000);
    check("rst_count", digit_count, 3'd0);
    check("rst_ack", code_ack, 1'b0);
    rst = 0; enable = 1;
    idle_step();

    digit(4'd2); digit(4'd4); digit(4'd6); digit(4'd8);
    check("r32_count4", digit_count, 3'd4);
    step(0, 4'd0, 0, 1);
    check("r32_ack_pre", code_ack, 1'b0);
    idle_step();
    check("r32_ack", code_ack, 1'b1);
    check("r32_code", code, 16'h2468);
    check("r32_count0", digit_count, 3'd0);
    idle_step();
    check("r32_ack_drop", code_ack, 1'b0);

    digit(4'd1); digit(4'd2); digit(4'd3);
    step(0, 4'd0, 0, 1);
    check("r33_err", entry_error, 1'b1);
    check("r33_count", digit_count, 3'd0);
    check("r33_code", code, 16'h2468);
    idle_step();
    check("r33_err_drop", entry_error, 1'b0);
    check("r33_ack", code_ack, 1'b0);

    digit(4'd1); digit(4'd2); digit(4'hA);
    check("r34_err", entry_error, 1'b1);
    check("r34_count2", digit_count, 3'd2);
    digit(4'd3); digit(4'd4); digit(4'd5);
    check("r34_full_err", entry_error, 1'b1);
    check("r34_count4", digit_count, 3'd4);
    step(0, 4'd0, 0, 1);
    idle_step();
    check("r34_ack", code_ack, 1'b1);
    check("r34_code", code, 16'h1234);

    digit(4'd9); digit(4'd8); digit(4'd7); digit(4'd6);
    step(0, 4'd0, 1, 1);
    check("r35_count", digit_count, 3'd0);
    check("r35_err", entry_error, 1'b0);
    idle_step();
    check("r35_ack", code_ack, 1'b0);
    check("r35_code", code, 16'h1234);

    digit(4'd5); digit(4'd5); digit(4'd5);
    enable = 0; idle_step();
    check("r36_dis_count", digit_count, 3'd0);
    enable = 1; idle_step();
    digit(4'd1); digit(4'd2);
    rst = 1; idle_step(); rst = 0;
    check("r36_count", digit_count, 3'd0);
    check("r36_code", code, 16'h0000);
    check("r36_ack", code_ack, 1'b0);

    idle_step();
    digit(4'd3); digit(4'd3); digit(4'd3); digit(4'd3);
    step(0, 4'd0, 0, 1);
    rst = 1; idle_step(); rst = 0;
    check("r29_ack", code_ack, 1'b0);
    check("r29_code", code, 16'h0000);

    idle_step();
    digit(4'd7);
    repeat (7) idle_step();
    check("r37_pre_tmo", timeout, 1'b0);
    check("r37_pre_count", digit_count, 3'd1);
    idle_step();
    check("r37_tmo", timeout, TMO_EN ? 1'b1 : 1'b0);
    check("r37_count", digit_count, TMO_EN ? 3'd0 : 3'd1);
    idle_step();
    check("r37_tmo_drop", timeout, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (enable) enable = ($urandom_range(0, 99) < 98);
      else enable = ($urandom_range(0, 99) < 30);
      key_valid = 0; key_clear = 0; key_enter = 0;
      if (quiet > 0) quiet--;
      else begin
        key_valid = ($urandom_range(0, 99) < 35);
        key_digit = ($urandom_range(0, 99) < 90) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
        key_clear = ($urandom_range(0, 99) < 4);
        key_enter = ($urandom_range(0, 99) < 12);
        if ($urandom_range(0, 99) < 3) quiet = $urandom_range(5, 12);
      end
      @(negedge clk);
    end
    rst = 0; key_valid = 0; key_clear = 0; key_enter = 0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
